// File: rtl/clkdiv_prog.sv
// Runtime-programmable integer clock divider / tick generator; divisor and high-time are loaded through a shadow and applied at period boundaries.
// Define CLKDIV_DUTY_EN to honour high_in/DEFAULT_HIGH; otherwise high-time is always N>>1.
module clkdiv_prog #(
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV  = 'd5000000,
  parameter logic [CNT_W-1:0] DEFAULT_HIGH = '0
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  output logic             clkout,
  output logic             tick,
  output logic             pending,
  output logic             err
);

`ifdef CLKDIV_DUTY_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  // Effective high-time: always lands in 1..n-1 for any legal n >= 2.
  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] n);
    if (!DUTY_EN || h == '0) return n >> 1;
    else if (h >= n)         return n - ONE;
    else                     return h;
  endfunction

  localparam logic [CNT_W-1:0] DEF_H = eff(DEFAULT_HIGH, DEFAULT_DIV);

  logic [CNT_W-1:0] r_count, r_div, r_high, r_sh_div, r_sh_high;
  logic             r_clkout, r_tick, r_pending, r_err;

  logic [CNT_W-1:0] w_next_count, w_in_high, w_div_nx, w_high_nx;
  logic             w_load_ok, w_load_bad, w_apply;

  always_comb begin
    w_load_ok  = load && (div_in >= TWO);
    w_load_bad = load && (div_in < TWO);
    w_in_high  = eff(high_in, div_in);

    if (!en)                                   w_next_count = '0;
    else if (r_count == r_div || r_count == '0) w_next_count = ONE;
    else                                       w_next_count = r_count + ONE;

    w_apply   = (w_next_count == ONE);
    w_div_nx  = r_div;
    w_high_nx = r_high;
    // A load landing on the boundary edge bypasses the shadow.
    if (w_apply) begin
      if (w_load_ok) begin
        w_div_nx  = div_in;
        w_high_nx = w_in_high;
      end else begin
        w_div_nx  = r_sh_div;
        w_high_nx = r_sh_high;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_count   <= '0;
      r_div     <= DEFAULT_DIV;
      r_high    <= DEF_H;
      r_sh_div  <= DEFAULT_DIV;
      r_sh_high <= DEF_H;
      r_clkout  <= 1'b0;
      r_tick    <= 1'b0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_div   <= w_div_nx;
      r_high  <= w_high_nx;
      if (w_load_ok) begin
        r_sh_div  <= div_in;
        r_sh_high <= w_in_high;
      end
      if (w_apply)        r_pending <= 1'b0;
      else if (w_load_ok) r_pending <= 1'b1;
      r_clkout <= (w_next_count >= ONE) && (w_next_count <= w_high_nx);
      r_tick   <= w_apply;
      r_err    <= w_load_bad;
    end
  end

  assign clkout  = r_clkout;
  assign tick    = r_tick;
  assign pending = r_pending;
  assign err     = r_err;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog with DEFAULT_DIV=10; per-cycle expected outputs flow through a scoreboard queue.
module tb_clkdiv_prog;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, en, load;
  logic [W-1:0] div_in, high_in;
  logic         clkout, tick, pending, err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] q_exp[$];
  string      q_tag[$];

  always #5 clk = ~clk;

  clkdiv_prog #(.CNT_W(W), .DEFAULT_DIV(W'(10)), .DEFAULT_HIGH(W'(0))) dut (
    .clkin(clk), .reset(reset), .en(en), .load(load),
    .div_in(div_in), .high_in(high_in),
    .clkout(clkout), .tick(tick), .pending(pending), .err(err)
  );

  // Expected high-time for a requested (h, n).
  function automatic int exp_h(input int h, input int n);
`ifdef CLKDIV_DUTY_EN
    if (h == 0) return n / 2;
    if (h >= n) return n - 1;
    return h;
`else
    return n / 2;
`endif
  endfunction

  task automatic push(input logic c, input logic t, input logic p, input logic e, input string tag);
    q_exp.push_back({c, t, p, e});
    q_tag.push_back(tag);
  endtask

  // One clkin edge, then compare {clkout,tick,pending,err} against the scoreboard head.
  task automatic cyc();
    logic [3:0] obs, expv;
    string tag;
    @(posedge clk);
    #1;
    obs = {clkout, tick, pending, err};
    n_tests++;
    if (q_exp.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %b, required an expected entry", obs);
    end else begin
      expv = q_exp.pop_front();
      tag  = q_tag.pop_front();
      assert (obs === expv) else begin
        n_fail++;
        $error("FAIL %s: observed {clkout,tick,pending,err}=%b expected %b", tag, obs, expv);
      end
    end
  endtask

  // Cycles first..last of a period of length n with high-time h.
  task automatic run(input int n, input int h, input int first, input int last, input logic p, input string tag);
    for (int i = first; i <= last; i++) begin
      push(i < h, i == 0, p, 1'b0, tag);
      cyc();
    end
  endtask

  initial begin
    int h4, h20;
    h4  = exp_h(1, 4);
    h20 = exp_h(20, 6);
    reset = 1'b1; en = 1'b0; load = 1'b0; div_in = '0; high_in = '0;
    push(0, 0, 0, 0, "reset_a"); cyc();
    push(0, 0, 0, 0, "reset_b"); cyc();

    reset = 1'b0; en = 1'b1;
    run(10, 5, 0, 9, 1'b0, "default_p1");
    run(10, 5, 0, 9, 1'b0, "default_p2");

    // Mid-period load: old period completes, then 4-cycle periods.
    run(10, 5, 0, 2, 1'b0, "default_p3");
    load = 1'b1; div_in = W'(4); high_in = W'(1);
    run(10, 5, 3, 3, 1'b1, "load4_capture");
    load = 1'b0;
    run(10, 5, 4, 9, 1'b1, "load4_pending");
    run(4, h4, 0, 3, 1'b0, "div4_p1");
    run(4, h4, 0, 3, 1'b0, "div4_p2");

    // Illegal divisors are rejected with a one-cycle err.
    run(4, h4, 0, 0, 1'b0, "err_pre");
    load = 1'b1; div_in = W'(1);
    push(1 < h4, 0, 0, 1, "err_div1"); cyc();
    div_in = W'(0);
    push(2 < h4, 0, 0, 1, "err_div0"); cyc();
    load = 1'b0;
    push(3 < h4, 0, 0, 0, "err_clear"); cyc();
    run(4, h4, 0, 3, 1'b0, "err_period_kept");

    // div 6, high 0 -> 50 %.
    run(4, h4, 0, 0, 1'b0, "ld6h0_pre");
    load = 1'b1; div_in = W'(6); high_in = W'(0);
    run(4, h4, 1, 1, 1'b1, "ld6h0_capture");
    load = 1'b0;
    run(4, h4, 2, 3, 1'b1, "ld6h0_pending");
    run(6, exp_h(0, 6), 0, 5, 1'b0, "p6h0_a");
    run(6, exp_h(0, 6), 0, 5, 1'b0, "p6h0_b");

    // div 6, high 20 -> clamped (or 50 % without duty control).
    run(6, 3, 0, 0, 1'b0, "ld6h20_pre");
    load = 1'b1; div_in = W'(6); high_in = W'(20);
    run(6, 3, 1, 1, 1'b1, "ld6h20_capture");
    load = 1'b0;
    run(6, 3, 2, 5, 1'b1, "ld6h20_pending");
    run(6, h20, 0, 5, 1'b0, "p6h20_a");
    run(6, h20, 0, 5, 1'b0, "p6h20_b");

    // en dropped mid-high, load while idle, restart with loaded values.
    run(6, h20, 0, 1, 1'b0, "stop_pre");
    en = 1'b0;
    push(0, 0, 0, 0, "en_drop"); cyc();
    load = 1'b1; div_in = W'(8); high_in = W'(0);
    push(0, 0, 1, 0, "idle_load"); cyc();
    load = 1'b0;
    push(0, 0, 1, 0, "idle_hold"); cyc();
    en = 1'b1;
    run(8, exp_h(0, 8), 0, 7, 1'b0, "restart8");

    // Load on the boundary edge applies immediately, pending never set.
    load = 1'b1; div_in = W'(4); high_in = W'(1);
    run(4, h4, 0, 0, 1'b0, "bypass_edge");
    load = 1'b0;
    run(4, h4, 1, 3, 1'b0, "bypass_rest");
    run(4, h4, 0, 3, 1'b0, "bypass_next");

    // Reset mid-period discards the pending load.
    run(4, h4, 0, 0, 1'b0, "rst_pre");
    load = 1'b1; div_in = W'(6); high_in = W'(0);
    run(4, h4, 1, 1, 1'b1, "rst_pending");
    load = 1'b0; reset = 1'b1;
    push(0, 0, 0, 0, "rst_mid"); cyc();
    reset = 1'b0;
    run(10, 5, 0, 9, 1'b0, "post_rst_a");
    run(10, 5, 0, 9, 1'b0, "post_rst_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
